// File: rtl/vliw_main_memory.sv
// vliw_main_memory: multi-port word memory with byte-lane writes, latency-1
// registered reads, a zero-fill sweep after reset or on request, and a sticky
// out-of-range access flag.
// Optional build macro: VLIW_MAIN_MEMORY_WR_BYPASS_EN -- when defined, a read of
// an address written in the same cycle returns the merged new data instead of
// the pre-write contents.
module vliw_main_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NWR    = 2,
    parameter int NRD    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    output logic                         busy,
    input  logic [NWR-1:0]               wr_en,
    input  logic [NWR*32-1:0]            wr_addr,
    input  logic [NWR*DATA_W-1:0]        wr_data,
    input  logic [NWR*(DATA_W/8)-1:0]    wr_be,
    input  logic [NRD-1:0]               rd_en,
    input  logic [NRD*32-1:0]            rd_addr,
    output logic [NRD*DATA_W-1:0]        rd_data,
    output logic [NRD-1:0]               rd_valid,
    output logic                         err,
    input  logic                         err_clr
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [ADDR_W-1:0]        idx_r;
    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic [NRD*DATA_W-1:0]    rd_data_r;
    logic [NRD-1:0]           rd_valid_r;
    logic                     err_r;

    logic                     run_s;
    logic [NWR-1:0]           wr_ok_s;
    logic [NWR-1:0]           wr_oor_s;
    logic [NRD-1:0]           rd_oor_s;
    logic                     any_err_s;
    logic [DATA_W-1:0]        rd_word_s [NRD];

    // An address is usable only when every bit above the index field is zero.
    function automatic logic in_range(input logic [31:0] addr);
        return ((addr >> ADDR_W) == 32'd0);
    endfunction

    // Overlay the enabled byte lanes of new_word onto old_word.
    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [NBYTES-1:0] be);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign run_s    = (state_r == RUN);
    assign busy     = (state_r == SWEEP);
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign err      = err_r;

    // Qualify each port's access: accepted only in RUN, split by address range.
    always_comb begin
        wr_ok_s  = '0;
        wr_oor_s = '0;
        rd_oor_s = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_ok_s[p]  = run_s && wr_en[p] &&  in_range(wr_addr[32*p +: 32]);
            wr_oor_s[p] = run_s && wr_en[p] && !in_range(wr_addr[32*p +: 32]);
        end
        for (int r = 0; r < NRD; r++) begin
            rd_oor_s[r] = run_s && rd_en[r] && !in_range(rd_addr[32*r +: 32]);
        end
        any_err_s = (|wr_oor_s) || (|rd_oor_s);
    end

    // Fetch the word for each read port, optionally merged with same-cycle writes.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_word_s[r] = mem_r[rd_addr[32*r +: ADDR_W]];
`ifdef VLIW_MAIN_MEMORY_WR_BYPASS_EN
            // Ascending port order gives the highest-index port the last word per lane.
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok_s[p] && (wr_addr[32*p +: ADDR_W] == rd_addr[32*r +: ADDR_W])) begin
                    rd_word_s[r] = merge_lanes(rd_word_s[r], wr_data[DATA_W*p +: DATA_W],
                                               wr_be[NBYTES*p +: NBYTES]);
                end else begin
                    rd_word_s[r] = rd_word_s[r];
                end
            end
`endif
        end
    end

    // Next-state logic: one full sweep, then RUN until a clear request.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            SWEEP: begin
                if (idx_r == {ADDR_W{1'b1}}) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = SWEEP;
                end
            end
            RUN: begin
                if (clr) begin
                    state_next_s = SWEEP;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = SWEEP;
        endcase
    end

    // State register; reset always lands in SWEEP so contents get zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SWEEP;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sweep index: advances during SWEEP (wrapping to 0 at the end), parked at 0 in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if (state_r == SWEEP) begin
            idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            idx_r <= '0;
        end
    end

    // Storage: zero-fill while sweeping, otherwise byte-lane writes (later port wins).
    always_ff @(posedge clk) begin
        if (state_r == SWEEP) begin
            mem_r[idx_r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_ok_s[p] && wr_be[NBYTES*p + b]) begin
                        mem_r[wr_addr[32*p +: ADDR_W]][8*b +: 8] <= wr_data[DATA_W*p + 8*b +: 8];
                    end
                end
            end
        end
    end

    // Registered read ports: data updates only on an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= '0;
        end else begin
            for (int r = 0; r < NRD; r++) begin
                rd_valid_r[r] <= run_s && rd_en[r];
                if (run_s && rd_en[r]) begin
                    rd_data_r[DATA_W*r +: DATA_W] <= rd_oor_s[r] ? {DATA_W{1'b0}} : rd_word_s[r];
                end
            end
        end
    end

    // Sticky error flag: a new error beats a same-cycle clear; frozen while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (run_s) begin
            if (any_err_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

endmodule
